// File: rtl/apple1_pkg.sv
// Shared types and constants for the Apple-1 PRG download path.
package apple1_pkg;

  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA} prg_state_t;

  localparam logic [15:0] RAM_TOP_DEFAULT = 16'hC000;

endpackage

// File: rtl/prg_loader.sv
// Parses a .PRG byte stream (2-byte little-endian load address + payload) into RAM writes.
// Optional build macro PRG_LOADER_CHECKSUM_EN adds a running payload checksum output.
//
// state  | meaning
// IDLE   | waiting for dl_active; last done/error held
// HDR_LO | expecting load address low byte
// HDR_HI | expecting load address high byte
// DATA   | payload bytes written at ptr until dl_active drops
module prg_loader
  import apple1_pkg::*;
#(
  parameter logic [15:0] RAM_TOP   = RAM_TOP_DEFAULT,
  parameter int          HDR_BYTES = 2
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        clk_ena,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_wr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] load_addr,
  output logic [15:0] end_addr
`ifdef PRG_LOADER_CHECKSUM_EN
  , output logic [7:0] checksum
`endif
);

  if (HDR_BYTES != 2) begin : g_hdr_check
    $error("prg_loader: HDR_BYTES must be 2");
  end

  prg_state_t  state, state_nx;
  logic [15:0] ptr, ptr_nx;
  logic        wrapped, wrapped_nx;
  logic [15:0] load_nx, end_nx, addr_nx;
  logic [7:0]  din_nx;
  logic        wr_nx, busy_nx, done_nx, err_nx;
  logic        accept;
  logic [7:0]  sum, sum_nx;

  assign accept = clk_ena & dl_wr & dl_active;

  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      wrapped   <= 1'b0;
      load_addr <= '0;
      end_addr  <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      sum       <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      wrapped   <= wrapped_nx;
      load_addr <= load_nx;
      end_addr  <= end_nx;
      ram_addr  <= addr_nx;
      ram_din   <= din_nx;
      ram_wr    <= wr_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      error     <= err_nx;
      sum       <= sum_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    wrapped_nx = wrapped;
    load_nx    = load_addr;
    end_nx     = end_addr;
    addr_nx    = ram_addr;
    din_nx     = ram_din;
    wr_nx      = ram_wr;
    busy_nx    = busy;
    done_nx    = done;
    err_nx     = error;
    sum_nx     = sum;
    if (clk_ena) begin
      // ram_wr lasts exactly one clk_ena period unless refreshed by an accept
      wr_nx = 1'b0;
      unique case (state)
        IDLE: begin
          if (dl_active) begin
            state_nx = HDR_LO;
            done_nx  = 1'b0;
            err_nx   = 1'b0;
            end_nx   = '0;
            busy_nx  = 1'b1;
            sum_nx   = '0;
          end
        end
        HDR_LO: begin
          if (accept) begin
            load_nx[7:0] = dl_data;
            state_nx     = HDR_HI;
          end else if (!dl_active) begin
            err_nx   = 1'b1;
            done_nx  = 1'b0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
        HDR_HI: begin
          if (accept) begin
            load_nx[15:8] = dl_data;
            ptr_nx        = {dl_data, load_addr[7:0]};
            end_nx        = {dl_data, load_addr[7:0]};
            wrapped_nx    = 1'b0;
            state_nx      = DATA;
          end else if (!dl_active) begin
            err_nx   = 1'b1;
            done_nx  = 1'b0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
        DATA: begin
          if (accept) begin
            ptr_nx = ptr + 16'd1;
            end_nx = ptr + 16'd1;
            sum_nx = sum + dl_data;
            if (wrapped || (ptr >= RAM_TOP)) begin
              err_nx = 1'b1;
            end else begin
              wr_nx   = 1'b1;
              addr_nx = ptr;
              din_nx  = dl_data;
            end
            if (ptr == 16'hFFFF) wrapped_nx = 1'b1;
          end else if (!dl_active) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef PRG_LOADER_CHECKSUM_EN
  assign checksum = sum;
`else
  logic unused_sum;
  assign unused_sum = ^sum;
`endif

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: driver pushes expected RAM writes, monitor pops on ram_wr.
module tb_prg_loader;
  import apple1_pkg::*;

  logic        sys_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        clk_ena   = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr     = 1'b0;
  logic [7:0]  dl_data   = 8'h00;
  logic [15:0] ram_addr, load_addr, end_addr;
  logic [7:0]  ram_din;
  logic        ram_wr, busy, done, error;
`ifdef PRG_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  prg_loader dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .clk_ena   (clk_ena),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_data   (dl_data),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wr    (ram_wr),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .load_addr (load_addr),
    .end_addr  (end_addr)
`ifdef PRG_LOADER_CHECKSUM_EN
    , .checksum (checksum)
`endif
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [7:0]  pay_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          gap = 0;
  bit          rand_gap = 1'b0;
  bit          rand_idle = 1'b0;
  int          hi_cycles = 0;
  logic        ena_q = 1'b0;

  // high-level model of the sticky status
  logic [15:0] m_load = '0;
  logic [15:0] m_end;
  logic        m_done, m_err;
  logic [7:0]  m_sum;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge sys_clock) ena_q <= clk_ena;

  always @(negedge sys_clock) begin
    if (ram_wr) hi_cycles++;
    if (ena_q && ram_wr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", ram_addr, ram_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(e.a));
        chk("wr_data", 32'(ram_din), 32'(e.d));
      end
    end
  end

  task automatic step(input logic a, input logic w, input logic [7:0] d);
    int g;
    g = rand_gap ? int'($urandom_range(0, 3)) : gap;
    repeat (g) begin
      @(negedge sys_clock);
      clk_ena = 1'b0; dl_active = a; dl_wr = w; dl_data = d;
    end
    @(negedge sys_clock);
    clk_ena = 1'b1; dl_active = a; dl_wr = w; dl_data = d;
  endtask

  task automatic maybe_idle();
    if (rand_idle && ($urandom_range(0, 3) == 0)) step(1'b1, 1'b0, 8'($urandom));
  endtask

  // Sends start + hdr_n header bytes (+ payload from pay_q if the header is complete), then ends.
  task automatic xfer(input logic [15:0] base, input int hdr_n);
    bit dropped;
    dropped = 1'b0;
    m_sum   = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    if (hdr_n >= 1) begin
      step(1'b1, 1'b1, base[7:0]);
      chk("busy_mid", 32'(busy), 32'd1);
      m_load[7:0] = base[7:0];
      maybe_idle();
    end
    if (hdr_n >= 2) begin
      step(1'b1, 1'b1, base[15:8]);
      m_load[15:8] = base[15:8];
      foreach (pay_q[i]) begin
        maybe_idle();
        if (int'(base) + i < int'(RAM_TOP_DEFAULT))
          exp_q.push_back('{a: 16'(int'(base) + i), d: pay_q[i]});
        else
          dropped = 1'b1;
        m_sum = m_sum + pay_q[i];
        step(1'b1, 1'b1, pay_q[i]);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    m_done = (hdr_n == 2);
    m_err  = (hdr_n < 2) || dropped;
    m_end  = (hdr_n == 2) ? 16'(int'(base) + pay_q.size()) : 16'h0000;
    @(negedge sys_clock);
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
    chk("busy_end", 32'(busy), 32'd0);
    chk("end_addr", 32'(end_addr), 32'(m_end));
    chk("load_addr", 32'(load_addr), 32'(m_load));
    chk("writes_left", 32'(exp_q.size()), 32'd0);
`ifdef PRG_LOADER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(m_sum));
`endif
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({nm, "_ram_din"}, 32'(ram_din), 32'd0);
    chk({nm, "_ram_wr"}, 32'(ram_wr), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
    chk({nm, "_load_addr"}, 32'(load_addr), 32'd0);
    chk({nm, "_end_addr"}, 32'(end_addr), 32'd0);
`ifdef PRG_LOADER_CHECKSUM_EN
    chk({nm, "_checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    int          sel;
    clk_ena = 1'b1;
    repeat (3) @(negedge sys_clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    xfer(16'h0301, 2);
    pay_q = '{8'h11, 8'h22, 8'h33};
    xfer(16'hBF00, 2);
    pay_q = '{};
    xfer(16'h0005, 1);
    xfer(16'h0200, 2);

    // reset mid-payload, then a fresh stream
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h40);
    exp_q.push_back('{a: 16'h4000, d: 8'hA1});
    step(1'b1, 1'b1, 8'hA1);
    exp_q.push_back('{a: 16'h4001, d: 8'hA2});
    step(1'b1, 1'b1, 8'hA2);
    @(negedge sys_clock);
    reset_n = 1'b0; clk_ena = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
    @(negedge sys_clock);
    check_reset_outputs("midreset");
    chk("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    reset_n = 1'b1;
    m_load = '0;
    pay_q = '{8'hEE};
    xfer(16'h0010, 2);

    // slow clk_ena with dl_wr held across non-enabled cycles
    gap = 6;
    pay_q = '{8'hFF, 8'hFF};
    hi_cycles = 0;
    xfer(16'h2000, 2);
    chk("wr_high_cycles", 32'(hi_cycles), 32'd14);
    gap = 0;

    // randomized streams
    rand_gap  = 1'b1;
    rand_idle = 1'b1;
    for (int t = 0; t < 16; t++) begin
      step(1'b0, 1'b1, 8'($urandom));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: base = 16'($urandom_range(16'hBFF0, 16'hBFFF));
        1: base = 16'($urandom_range(16'hFFF4, 16'hFFFF));
        default: base = 16'($urandom_range(0, 16'hBFFF));
      endcase
      pay_q = '{};
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) pay_q.push_back(8'($urandom));
      xfer(base, (t % 7 == 3) ? int'($urandom_range(0, 1)) : 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
